// File: rtl/sequential_divider_if.sv
// Handshake/data bundle for sequential_divider.
// The master drives the operands and start pulse; the slave (the divider)
// returns busy, the results and the one-cycle enOut strobe.
interface sequential_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             enOut;

  modport master (
    output start, in1, in2,
    input  busy, quotient, remainder, div_by_zero, enOut
  );

  modport slave (
    input  start, in1, in2,
    output busy, quotient, remainder, div_by_zero, enOut
  );
endinterface

// File: rtl/sequential_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// IDLE captures operands, RUN performs WIDTH shift/trial-subtract steps,
// FINISH applies signs and loads the registered outputs with a one-cycle enOut.
// Divide by zero skips RUN: quotient all ones, remainder = dividend.
// Build option: define DIV_SIGNED_EN for two's-complement signed division;
// without it operands are treated as unsigned.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  sequential_divider_if.slave  div_bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_busy;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_dbz;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz_out;
  logic             r_en_out;

  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_in2_zero;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

`ifdef DIV_SIGNED_EN
  logic             r_sign_q;
  logic             r_sign_r;
  logic             w_sign_q;
  logic             w_sign_r;

  // Magnitudes; the most-negative value maps to the unsigned 2^(WIDTH-1).
  assign w_abs1   = div_bus.in1[WIDTH-1] ? -div_bus.in1 : div_bus.in1;
  assign w_abs2   = div_bus.in2[WIDTH-1] ? -div_bus.in2 : div_bus.in2;
  assign w_sign_q = div_bus.in1[WIDTH-1] ^ div_bus.in2[WIDTH-1];
  assign w_sign_r = div_bus.in1[WIDTH-1];
`else
  assign w_abs1   = div_bus.in1;
  assign w_abs2   = div_bus.in2;
`endif

  assign w_in2_zero = (div_bus.in2 == '0);

  // Trial subtraction on WIDTH+1 bits: a set top bit of the shifted
  // remainder always exceeds the divisor, otherwise the difference sign decides.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_ge       = w_rem_sh[WIDTH] | ~w_diff[WIDTH];
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and busy indication.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div_bus.start) begin
          w_accept     = 1'b1;
          w_state_next = w_in2_zero ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_state_next = S_FINISH;
      end
      S_FINISH: begin
        w_busy       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz_out   <= 1'b0;
      r_en_out    <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
`endif
    end else begin
      r_en_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_div <= w_abs2;
            r_dbz <= w_in2_zero;
            // Divide by zero preloads the final answer so FINISH needs no special path.
            r_rem <= w_in2_zero ? div_bus.in1 : '0;
            r_quo <= w_in2_zero ? '1 : w_abs1;
`ifdef DIV_SIGNED_EN
            r_sign_q <= w_sign_q & ~w_in2_zero;
            r_sign_r <= w_sign_r & ~w_in2_zero;
`endif
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FINISH: begin
`ifdef DIV_SIGNED_EN
          r_quotient  <= r_sign_q ? -r_quo : r_quo;
          r_remainder <= r_sign_r ? -r_rem : r_rem;
`else
          r_quotient  <= r_quo;
          r_remainder <= r_rem;
`endif
          r_dbz_out   <= r_dbz;
          r_en_out    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign div_bus.busy        = w_busy;
  assign div_bus.quotient    = r_quotient;
  assign div_bus.remainder   = r_remainder;
  assign div_bus.div_by_zero = r_dbz_out;
  assign div_bus.enOut       = r_en_out;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases plus randomized
// operands compared against a plain-arithmetic reference model.
module tb_sequential_divider;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sequential_divider_if #(.WIDTH(W)) bus ();
  sequential_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .div_bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  always @(negedge clk) if (bus.enOut === 1'b1) en_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with 64-bit intermediates.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.enOut !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
      if (bus.enOut !== 1'b1 && bus.busy === 1'b1) busy_cnt++;
    end
    chk("done_seen", {63'd0, bus.enOut}, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    int           edges, bc, lat;
    model(a, b, eq, er, ez);
    lat = (b == '0) ? 1 : W + 1;
    start_op(a, b);
    wait_done(edges, bc);
    chk("latency",   64'(edges), 64'(lat));
    chk("busy_cyc",  64'(bc), 64'(lat));
    chk("busy_at_en", {63'd0, bus.busy}, 64'd0);
    chk("quotient",  {32'd0, bus.quotient},  {32'd0, eq});
    chk("remainder", {32'd0, bus.remainder}, {32'd0, er});
    chk("dbz",       {63'd0, bus.div_by_zero}, {63'd0, ez});
  endtask

  initial begin
    int c0, edges, bc;
    logic [W-1:0] a, b;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;

    // Reset state
    #12;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_en",   {63'd0, bus.enOut}, 64'd0);
    chk("rst_q",    {32'd0, bus.quotient}, 64'd0);
    chk("rst_r",    {32'd0, bus.remainder}, 64'd0);
    chk("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases, issued back to back
    run_op(32'd100, 32'd7);
    chk("basic_q", {32'd0, bus.quotient}, 64'd14);
    chk("basic_r", {32'd0, bus.remainder}, 64'd2);
    run_op(32'hFFFF_FF9C, 32'd7);
    run_op(32'd5, 32'd0);
    chk("dbz_q", {32'd0, bus.quotient}, 64'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd13, 32'd1);

    // start while busy is ignored; next start in the enOut cycle is taken
    @(negedge clk);
    c0 = en_cnt;
    start_op(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.in1 = 32'd9; bus.in2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, bc);
    chk("busy_ign_lat", 64'(edges), 64'd24);
    chk("busy_ign_q", {32'd0, bus.quotient}, 64'd14);
    chk("busy_ign_r", {32'd0, bus.remainder}, 64'd2);
    run_op(32'd9, 32'd3);
    @(negedge clk);
    chk("en_pulses", 64'(en_cnt - c0), 64'd2);

    // Asynchronous reset mid-operation
    c0 = en_cnt;
    start_op(32'd100, 32'd7);
    repeat (13) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_en",   {63'd0, bus.enOut}, 64'd0);
    chk("arst_q",    {32'd0, bus.quotient}, 64'd0);
    chk("arst_r",    {32'd0, bus.remainder}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_en", 64'(en_cnt - c0), 64'd0);
    run_op(32'd50, 32'd5);
    chk("post_rst_q", {32'd0, bus.quotient}, 64'd10);
    chk("post_rst_r", {32'd0, bus.remainder}, 64'd0);

    // Randomized operands, including edge values
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = W'($urandom_range(1, 20));
        3: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
